// File: rtl/ex_result_stage.sv
// -----------------------------------------------------------------------------
// ex_result_stage
//   EX->MEM boundary register for the 32-bit adder's S/Z/V/N outputs.
//   - Registers the adder result behind a valid/ready handshake toward MEM.
//   - Signed overflow (alu_sign & alu_v) becomes a MIPS Ov exception. The
//     writeback is suppressed, and EPC/cause are held until exc_ack.
//   - Unsigned overflow is reported on out_carry and does not trap.
//   Optional feature: define EX_OVF_COUNT_EN to add a saturating 16-bit
//   counter of trapping accepts on output ovf_count.
// -----------------------------------------------------------------------------
module ex_result_stage #(
   parameter int          DATA_W   = 32,
   parameter int          REG_W    = 5,
   parameter int unsigned OV_CAUSE = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   // EX side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_s,
   input  logic              alu_z,
   input  logic              alu_v,
   input  logic              alu_n,
   input  logic              alu_sign,
   input  logic              wr_en_in,
   input  logic [REG_W-1:0]  wr_reg_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              flush,
   // MEM side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_z,
   output logic              out_n,
   output logic              out_carry,
   output logic              out_wr_en,
   output logic [REG_W-1:0]  out_wr_reg,
   // CP0 / exception unit
   output logic              exc_req,
   output logic [DATA_W-1:0] exc_epc,
   output logic [4:0]        exc_cause,
   input  logic              exc_ack
`ifdef EX_OVF_COUNT_EN
   ,
   output logic [15:0]       ovf_count
`endif
);

   localparam logic [4:0] LP_OV_CAUSE = 5'(OV_CAUSE);

   typedef enum logic {
      ST_RUN = 1'b0,   // normal pipelined operation
      ST_EXC = 1'b1    // overflow exception held for the exception unit
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_ready_core;
   logic                w_accept;
   logic                w_trap;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_result;
   logic                r_out_z;
   logic                r_out_n;
   logic                r_out_carry;
   logic                r_out_wr_en;
   logic [REG_W-1:0]    r_out_wr_reg;
   logic                r_exc_req;
   logic [DATA_W-1:0]   r_exc_epc;
   logic [4:0]          r_exc_cause;

   // State register.
   // NOTE: sequential state is always updated with non-blocking (<=) assignments
   // so every flop samples values from before the edge, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and the accept/trap decode for this cycle.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_ready_core = 1'b0;
      w_accept     = 1'b0;
      w_trap       = 1'b0;
      case (r_state)
         ST_RUN: begin
            // A flush cycle never accepts. Otherwise the slot is free when empty
            // or when its current occupant leaves this cycle.
            w_ready_core = !flush && (!r_out_valid || out_ready);
            w_accept     = in_valid && w_ready_core;
            w_trap       = w_accept && alu_sign && alu_v;
            if (w_trap) begin
               w_state_nxt = ST_EXC;
            end
         end
         ST_EXC: begin
            // Acknowledge cycle returns to RUN, but accepts nothing itself.
            if (exc_ack) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
      // Flush has highest priority and always lands in RUN.
      if (flush) begin
         w_state_nxt = ST_RUN;
      end
   end

   // Result register and exception holding registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_z      <= 1'b0;
         r_out_n      <= 1'b0;
         r_out_carry  <= 1'b0;
         r_out_wr_en  <= 1'b0;
         r_out_wr_reg <= '0;
         r_exc_req    <= 1'b0;
         r_exc_epc    <= '0;
         r_exc_cause  <= '0;
      end else if (flush) begin
         // Squash the held entry and any pending exception. The data fields may
         // keep stale values because out_valid hides them.
         r_out_valid  <= 1'b0;
         r_exc_req    <= 1'b0;
         r_exc_epc    <= '0;
         r_exc_cause  <= '0;
      end else if (r_state == ST_EXC) begin
         // out_valid is already 0 here. Only the acknowledge can change anything.
         if (exc_ack) begin
            r_exc_req   <= 1'b0;
            r_exc_epc   <= '0;
            r_exc_cause <= '0;
         end
      end else if (w_accept) begin
         // Z/N/S pass through untouched, even for a faulting entry.
         r_out_result <= alu_s;
         r_out_z      <= alu_z;
         r_out_n      <= alu_n;
         r_out_wr_reg <= wr_reg_in;
         // Carry is only meaningful for unsigned ops. Signed ops report 0.
         r_out_carry  <= !alu_sign && alu_v;
         if (w_trap) begin
            // Faulting instruction: no result toward MEM, never a GPR write.
            r_out_valid <= 1'b0;
            r_out_wr_en <= 1'b0;
            r_exc_req   <= 1'b1;
            r_exc_epc   <= pc_in;
            r_exc_cause <= LP_OV_CAUSE;
         end else begin
            r_out_valid <= 1'b1;
            r_out_wr_en <= wr_en_in;
         end
      end else if (out_ready) begin
         // MEM consumed the entry and nothing new arrived.
         r_out_valid <= 1'b0;
      end
   end

`ifdef EX_OVF_COUNT_EN
   logic [15:0] r_ovf_count;

   // Saturating count of trapping accepts. Flush does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_count <= '0;
      end else if (w_trap && (r_ovf_count != 16'hFFFF)) begin
         r_ovf_count <= r_ovf_count + 16'd1;
      end
   end

   assign ovf_count = r_ovf_count;
`endif

   // in_ready is forced low while reset is asserted, so every output reads 0
   // during reset. The internal accept path does not depend on rst_n.
   assign in_ready   = rst_n && w_ready_core;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_z      = r_out_z;
   assign out_n      = r_out_n;
   assign out_carry  = r_out_carry;
   assign out_wr_en  = r_out_wr_en;
   assign out_wr_reg = r_out_wr_reg;
   assign exc_req    = r_exc_req;
   assign exc_epc    = r_exc_epc;
   assign exc_cause  = r_exc_cause;

endmodule

// File: tb/tb_ex_result_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_result_stage
//   Scoreboard bench for ex_result_stage. Expected MEM-side entries are queued
//   when stimulus is driven and popped when the DUT hands an entry to MEM.
//   Build with EX_OVF_COUNT_EN defined to also check ovf_count.
// -----------------------------------------------------------------------------
module tb_ex_result_stage;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        carry;
      logic        we;
      logic [4:0]  rg;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_s;
   logic        alu_z;
   logic        alu_v;
   logic        alu_n;
   logic        alu_sign;
   logic        wr_en_in;
   logic [4:0]  wr_reg_in;
   logic [31:0] pc_in;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_z;
   logic        out_n;
   logic        out_carry;
   logic        out_wr_en;
   logic [4:0]  out_wr_reg;
   logic        exc_req;
   logic [31:0] exc_epc;
   logic [4:0]  exc_cause;
   logic        exc_ack;
`ifdef EX_OVF_COUNT_EN
   logic [15:0] ovf_count;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_ovf  = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   ex_result_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_s      (alu_s),
      .alu_z      (alu_z),
      .alu_v      (alu_v),
      .alu_n      (alu_n),
      .alu_sign   (alu_sign),
      .wr_en_in   (wr_en_in),
      .wr_reg_in  (wr_reg_in),
      .pc_in      (pc_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_z      (out_z),
      .out_n      (out_n),
      .out_carry  (out_carry),
      .out_wr_en  (out_wr_en),
      .out_wr_reg (out_wr_reg),
      .exc_req    (exc_req),
      .exc_epc    (exc_epc),
      .exc_cause  (exc_cause),
      .exc_ack    (exc_ack)
`ifdef EX_OVF_COUNT_EN
      ,
      .ovf_count  (ovf_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_ovf(input string tag);
`ifdef EX_OVF_COUNT_EN
      check(tag, 64'(ovf_count), 64'(exp_ovf));
`else
      n_checks = n_checks + 0;
`endif
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),   64'd0);
      check({tag, "_out_valid"}, 64'(out_valid),  64'd0);
      check({tag, "_result"},    64'(out_result), 64'd0);
      check({tag, "_z"},         64'(out_z),      64'd0);
      check({tag, "_n"},         64'(out_n),      64'd0);
      check({tag, "_carry"},     64'(out_carry),  64'd0);
      check({tag, "_wr_en"},     64'(out_wr_en),  64'd0);
      check({tag, "_wr_reg"},    64'(out_wr_reg), 64'd0);
      check({tag, "_exc_req"},   64'(exc_req),    64'd0);
      check({tag, "_epc"},       64'(exc_epc),    64'd0);
      check({tag, "_cause"},     64'(exc_cause),  64'd0);
      check_ovf({tag, "_ovf_count"});
   endtask

   // Drive one EX-side beat (held until the caller changes it).
   task automatic drive(input logic v, input logic [31:0] s, input logic z, input logic ov,
                        input logic n, input logic sign, input logic we,
                        input logic [4:0] rg, input logic [31:0] pc);
      in_valid  = v;
      alu_s     = s;
      alu_z     = z;
      alu_v     = ov;
      alu_n     = n;
      alu_sign  = sign;
      wr_en_in  = we;
      wr_reg_in = rg;
      pc_in     = pc;
   endtask

   // Queue the entry MEM must eventually see for a non-trapping accept.
   task automatic expect_entry(input logic [31:0] s, input logic z, input logic ov,
                               input logic n, input logic sign, input logic we,
                               input logic [4:0] rg);
      exp_t e;
      e.res   = s;
      e.z     = z;
      e.n     = n;
      e.carry = !sign && ov;
      e.we    = we;
      e.rg    = rg;
      exp_q.push_back(e);
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   // MEM-side monitor: a handshake seen mid-cycle completes at the next edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("sb_entry_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("sb_result", 64'(out_result), 64'(mon_e.res));
            check("sb_z",      64'(out_z),      64'(mon_e.z));
            check("sb_n",      64'(out_n),      64'(mon_e.n));
            check("sb_carry",  64'(out_carry),  64'(mon_e.carry));
            check("sb_wr_en",  64'(out_wr_en),  64'(mon_e.we));
            check("sb_wr_reg", 64'(out_wr_reg), 64'(mon_e.rg));
         end
      end
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rs;
      rst_n     = 1'b1;
      out_ready = 1'b0;
      flush     = 1'b0;
      exc_ack   = 1'b0;
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 rst_n = 1'b0;
      #1 check_all_zero("reset");
      #10 rst_n = 1'b1;                 // released away from a rising edge
      to_pos();

      // 1: signed 5+7 -> 12 into r8
      out_ready = 1'b1;
      drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0040_0000);
      expect_entry(32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8);
      to_neg(); check("t1_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0;
      to_neg(); check("t1_out_valid", 64'(out_valid), 64'd1);
                check("t1_exc_req", 64'(exc_req), 64'd0);
      to_pos();

      // 2: signed 0x7FFFFFFF+1 overflows -> exception
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0040_0020);
      to_neg(); check("t2_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0; exp_ovf++;
      to_neg(); check("t2_exc_req", 64'(exc_req), 64'd1);
                check("t2_epc", 64'(exc_epc), 64'h0040_0020);
                check("t2_cause", 64'(exc_cause), 64'd12);
                check("t2_out_valid", 64'(out_valid), 64'd0);
                check("t2_in_ready_exc", 64'(in_ready), 64'd0);
                check_ovf("t2_ovf_count");
      to_pos();
      // Ack cycle: a presented input must not be taken.
      exc_ack = 1'b1;
      drive(1'b1, 32'd99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0040_0024);
      to_neg(); check("t2_in_ready_ack", 64'(in_ready), 64'd0);
                check("t2_exc_req_ack", 64'(exc_req), 64'd1);
      to_pos(); exc_ack = 1'b0; in_valid = 1'b0;
      to_neg(); check("t2_exc_req_clr", 64'(exc_req), 64'd0);
                check("t2_cause_clr", 64'(exc_cause), 64'd0);
                check("t2_epc_clr", 64'(exc_epc), 64'd0);
                check("t2_in_ready_after", 64'(in_ready), 64'd1);
                check("t2_no_out", 64'(out_valid), 64'd0);
      to_pos();

      // 3: unsigned 0xFFFFFFFF+1 -> carry, no trap
      drive(1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0040_0028);
      expect_entry(32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
      to_neg(); check("t3_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0;
      to_neg(); check("t3_out_valid", 64'(out_valid), 64'd1);
                check("t3_exc_req", 64'(exc_req), 64'd0);
      to_pos();

      // No GPR write (compare result): valid entry, wr_en low
      drive(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0040_002C);
      expect_entry(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
      to_neg(); check("nowr_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0;
      to_neg(); check("nowr_out_valid", 64'(out_valid), 64'd1);
      to_pos();

      // 4: backpressure hold, then release accepts the waiting input same cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0040_0030);
      expect_entry(32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
      to_neg(); check("t4_in_ready", 64'(in_ready), 64'd1);
      to_pos();
      drive(1'b1, 32'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0040_0034);
      for (int i = 0; i < 3; i++) begin
         to_neg(); check("t4_hold_result", 64'(out_result), 64'h1234);
                   check("t4_hold_valid", 64'(out_valid), 64'd1);
                   check("t4_hold_in_ready", 64'(in_ready), 64'd0);
         to_pos();
      end
      out_ready = 1'b1;
      expect_entry(32'h5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10);
      to_neg(); check("t4_release_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0;
      to_neg(); check("t4_second_valid", 64'(out_valid), 64'd1);
      to_pos();

      // Back-to-back stream, then a trap while the last entry leaves
      for (int i = 0; i < 8; i++) begin
         rs = $urandom;
         drive(1'b1, rs, rs == 0, 1'b0, rs[31], 1'(i % 2), 1'b1, 5'(i + 16), 32'h0040_0100 + 32'(i * 4));
         expect_entry(rs, rs == 0, 1'b0, rs[31], 1'(i % 2), 1'b1, 5'(i + 16));
         to_neg(); check("b2b_in_ready", 64'(in_ready), 64'd1);
         to_pos();
      end
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0040_0200);
      to_neg(); check("b2b_trap_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0; exp_ovf++;
      to_neg(); check("b2b_trap_exc_req", 64'(exc_req), 64'd1);
                check("b2b_trap_epc", 64'(exc_epc), 64'h0040_0200);
                check("b2b_trap_out_valid", 64'(out_valid), 64'd0);
      to_pos();

      // 5a: flush while in EXC
      flush = 1'b1;
      to_neg(); check("t5_flush_in_ready", 64'(in_ready), 64'd0);
      to_pos(); flush = 1'b0;
      to_neg(); check("t5_exc_req", 64'(exc_req), 64'd0);
                check("t5_cause", 64'(exc_cause), 64'd0);
                check("t5_out_valid", 64'(out_valid), 64'd0);
                check("t5_in_ready_run", 64'(in_ready), 64'd1);
                check_ovf("t5_ovf_count");
      to_pos();

      // 5b: flush together with exc_ack
      drive(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0040_0300);
      to_neg(); check("t5b_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0; exp_ovf++;
      to_neg(); check("t5b_exc_req", 64'(exc_req), 64'd1);
      to_pos(); flush = 1'b1; exc_ack = 1'b1;
      to_neg(); check("t5b_flush_in_ready", 64'(in_ready), 64'd0);
      to_pos(); flush = 1'b0; exc_ack = 1'b0;
      to_neg(); check("t5b_exc_req_clr", 64'(exc_req), 64'd0);
                check("t5b_cause_clr", 64'(exc_cause), 64'd0);
                check("t5b_out_valid", 64'(out_valid), 64'd0);
                check("t5b_in_ready", 64'(in_ready), 64'd1);
                check_ovf("t5b_ovf_count");
      to_pos();

      // exc_ack while in RUN has no effect
      exc_ack = 1'b1;
      drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0040_0400);
      expect_entry(32'hCAFE_0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12);
      to_neg(); check("ackrun_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0; exc_ack = 1'b0;
      to_neg(); check("ackrun_out_valid", 64'(out_valid), 64'd1);
                check("ackrun_exc_req", 64'(exc_req), 64'd0);
      to_pos();

      // Flush in RUN squashes a held entry (MEM never takes it)
      out_ready = 1'b0;
      drive(1'b1, 32'hDEAD_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd13, 32'h0040_0500);
      to_neg();
      to_pos(); in_valid = 1'b0;
      to_neg(); check("flushrun_held", 64'(out_valid), 64'd1);
      to_pos(); flush = 1'b1;
      to_neg(); check("flushrun_in_ready", 64'(in_ready), 64'd0);
      to_pos(); flush = 1'b0;
      to_neg(); check("flushrun_out_valid", 64'(out_valid), 64'd0);
                check("flushrun_in_ready_after", 64'(in_ready), 64'd1);
      to_pos();

      // 6: asynchronous reset during a hold
      drive(1'b1, 32'hABCD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 32'h0040_0600);
      to_neg();
      to_pos(); in_valid = 1'b0;
      to_neg(); check("t6_held", 64'(out_valid), 64'd1);
                check("t6_held_result", 64'(out_result), 64'hABCD);
      #2 rst_n = 1'b0;
      exp_ovf = 0;
      #1 check_all_zero("t6_async");
      to_neg(); rst_n = 1'b1;
      to_pos();

      // Normal operation resumes after reset
      out_ready = 1'b1;
      drive(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0040_0700);
      expect_entry(32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2);
      to_neg(); check("post_rst_in_ready", 64'(in_ready), 64'd1);
      to_pos(); in_valid = 1'b0;
      to_neg(); check("post_rst_out_valid", 64'(out_valid), 64'd1);
      to_pos();
      to_neg();

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
